// File: rtl/decoder_pipeline_ctrl.sv
// decoder_pipeline_ctrl
//   Sequencer and configuration owner for the 3-stage fixed-point decoder
//   (mult -> adder tree -> bias). Owns the weight/bias bank (serial config
//   port), admits input vectors via valid/ready, tracks them through the
//   non-stallable decoder with a valid shift register and buffers results in
//   an output FIFO. Admission is credit-based so a FIFO push never finds the
//   FIFO full.
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   in_valid/in_ready/in_z          input vector handshake
//   out_valid/out_ready/out_data    FIFO head handshake
//   cfg_req/cfg_ack/cfg_wr/cfg_addr/cfg_wdata/cfg_done/cfg_err  config port
//   dec_z/dec_w/dec_b               drive the decoder (z registered, w/b bank)
//   dec_out                         decoder result, LATENCY edges after dec_z
module decoder_pipeline_ctrl #(
  parameter int N_INPUT    = 2,
  parameter int M_OUTPUT   = 9,
  parameter int BITSIZE    = 16,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int NW  = N_INPUT*M_OUTPUT + M_OUTPUT,
  localparam int CAW = $clog2(NW)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N_INPUT*BITSIZE-1:0]          in_z,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [M_OUTPUT*BITSIZE-1:0]         out_data,
  input  logic                                cfg_req,
  output logic                                cfg_ack,
  input  logic                                cfg_wr,
  input  logic [CAW-1:0]                      cfg_addr,
  input  logic [BITSIZE-1:0]                  cfg_wdata,
  input  logic                                cfg_done,
  output logic                                cfg_err,
  output logic [N_INPUT*BITSIZE-1:0]          dec_z,
  output logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] dec_w,
  output logic [M_OUTPUT*BITSIZE-1:0]         dec_b,
  input  logic [M_OUTPUT*BITSIZE-1:0]         dec_out
);
  localparam int NWW = N_INPUT*M_OUTPUT;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int PBW = $clog2(LATENCY+2);
  localparam int SW  = $clog2(LATENCY+FIFO_DEPTH+2);
  localparam logic [CAW:0] NW_L = (CAW+1)'(NW);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                    r_state, w_state_nxt;
  logic                          r_cfg_ack, r_cfg_err;
  logic [BITSIZE-1:0]            r_bank [NW];
  logic [N_INPUT*BITSIZE-1:0]    r_dec_z;
  // Bit i set = a vector accepted i edges ago; bit LATENCY means dec_out
  // now holds its result, so it is pushed at the coming edge.
  logic [LATENCY:0]              r_vld_sr;
  logic [M_OUTPUT*BITSIZE-1:0]   r_fifo [FIFO_DEPTH];
  logic [FAW-1:0]                r_wptr, r_rptr;
  logic [FAW:0]                  r_count;
  logic [PBW-1:0]                w_pipe_busy;
  logic [SW-1:0]                 w_credit_used;
  logic                          w_accept, w_push, w_pop, w_addr_ok, w_load_wr;

  always_comb begin
    w_pipe_busy = '0;
    for (int i = 0; i <= LATENCY; i++) w_pipe_busy = w_pipe_busy + PBW'(r_vld_sr[i]);
  end

  // Every vector not yet popped holds a credit, so a push always has room
  // even if out_ready stays low from now on.
  assign w_credit_used = SW'(w_pipe_busy) + SW'(r_count);
  assign in_ready  = (r_state == S_RUN) && (w_credit_used < SW'(FIFO_DEPTH));
  assign w_accept  = in_valid && in_ready;
  assign w_push    = r_vld_sr[LATENCY];
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_data  = out_valid ? r_fifo[r_rptr] : '0;
  assign w_addr_ok = ({1'b0, cfg_addr} < NW_L);
  assign w_load_wr = (r_state == S_LOAD) && cfg_wr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (cfg_done)            w_state_nxt = S_RUN;
      S_RUN:   if (cfg_req)             w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pipe_busy == '0)   w_state_nxt = S_LOAD;
      default:                          w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_LOAD;
      r_cfg_ack <= 1'b1;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_ack <= (w_state_nxt == S_LOAD);
      if (r_state != S_LOAD && w_state_nxt == S_LOAD) r_cfg_err <= 1'b0;
      else if (w_load_wr && !w_addr_ok)               r_cfg_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NW; k++) r_bank[k] <= '0;
    end else if (w_load_wr && w_addr_ok) begin
      r_bank[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dec_z  <= '0;
      r_vld_sr <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      r_vld_sr <= {r_vld_sr[LATENCY-1:0], w_accept};
      if (w_accept) r_dec_z <= in_z;
      if (w_push)   r_wptr  <= r_wptr + FAW'(1);
      if (w_pop)    r_rptr  <= r_rptr + FAW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage only; the occupancy count decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= dec_out;
  end

  for (genvar k = 0; k < NWW; k++) begin : g_w
    assign dec_w[k*BITSIZE +: BITSIZE] = r_bank[k];
  end
  for (genvar j = 0; j < M_OUTPUT; j++) begin : g_b
    assign dec_b[j*BITSIZE +: BITSIZE] = r_bank[NWW+j];
  end

  assign dec_z   = r_dec_z;
  assign cfg_ack = r_cfg_ack;
  assign cfg_err = r_cfg_err;
endmodule

// File: tb/tb_decoder_pipeline_ctrl.sv
module tb_decoder_pipeline_ctrl;
  localparam int N = 2, M = 9, B = 16, FD = 4, NW = N*M + M, NWW = N*M;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [N*B-1:0] in_z = '0;
  logic [M*B-1:0] out_data, dec_b, dec_out;
  logic cfg_req = 1'b0, cfg_ack, cfg_wr = 1'b0, cfg_done = 1'b0, cfg_err;
  logic [4:0] cfg_addr = '0;
  logic [B-1:0] cfg_wdata = '0;
  logic [N*B-1:0] dec_z;
  logic [N*M*B-1:0] dec_w;

  logic [N*M*B-1:0] exp_w;
  logic [M*B-1:0] exp_b, exp_o;
  logic [M*B-1:0] s1 = '0, s2 = '0, s3 = '0;
  logic [M*B-1:0] sb[$];
  int checks = 0, errors = 0, cyc = 0;

  decoder_pipeline_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_req(cfg_req), .cfg_ack(cfg_ack), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .dec_z(dec_z), .dec_w(dec_w), .dec_b(dec_b), .dec_out(dec_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in decoder: any 3-edge pipeline whose result depends on z.
  function automatic logic [M*B-1:0] dec_f(input logic [N*B-1:0] z);
    logic [M*B-1:0] r;
    for (int j = 0; j < M; j++) r[j*B +: B] = z[B-1:0] + (z[2*B-1:B] << 4) + 16'(j*3+1);
    return r;
  endfunction
  always @(posedge clk) begin s1 <= dec_f(dec_z); s2 <= s1; s3 <= s2; end
  assign dec_out = s3;

  // Scoreboard: push expected result at acceptance, compare at pop.
  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL pop_unexpected got=%h exp=none", out_data);
        end else begin
          exp_o = sb.pop_front();
          if (out_data !== exp_o) begin errors++; $display("FAIL result got=%h exp=%h", out_data, exp_o); end
        end
      end
      if (in_valid && in_ready) sb.push_back(dec_f(in_z));
      checks++;
      if (sb.size() > FD) begin errors++; $display("FAIL fifo_overflow outstanding=%0d max=%0d", sb.size(), FD); end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int g = 0;
    out_ready = 1'b1; in_valid = 1'b0;
    while (sb.size() != 0 && g < 50) begin tick; g++; end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL %s_drain left=%0d exp=0", name, sb.size()); end
  endtask

  task automatic test_reset;
    repeat (3) tick;
    checks += 8;
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (out_data !== '0)    begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    if (cfg_ack !== 1'b1)   begin errors++; $display("FAIL rst_cfg_ack got=%b exp=1", cfg_ack); end
    if (cfg_err !== 1'b0)   begin errors++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); end
    if (dec_z !== '0)       begin errors++; $display("FAIL rst_dec_z got=%h exp=0", dec_z); end
    if (dec_w !== '0)       begin errors++; $display("FAIL rst_dec_w got=%h exp=0", dec_w); end
    if (dec_b !== '0)       begin errors++; $display("FAIL rst_dec_b got=%h exp=0", dec_b); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_config;
    for (int k = 0; k < NWW; k++) exp_w[k*B +: B] = 16'(k+1);
    for (int j = 0; j < M; j++)   exp_b[j*B +: B] = 16'h0100;
    for (int k = 0; k < NW; k++) begin
      cfg_wr = 1'b1; cfg_addr = 5'(k);
      cfg_wdata = (k < NWW) ? 16'(k+1) : 16'h0100;
      cfg_done = (k == NW-1);   // last write shares the edge with cfg_done
      if (k == 5) begin
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL load_in_ready got=%b exp=0", in_ready); end
        if (cfg_ack !== 1'b1)  begin errors++; $display("FAIL load_cfg_ack got=%b exp=1", cfg_ack); end
      end
      tick;
    end
    cfg_wr = 1'b0; cfg_done = 1'b0;
    checks += 4;
    if (dec_w !== exp_w)   begin errors++; $display("FAIL cfg_dec_w got=%h exp=%h", dec_w, exp_w); end
    if (dec_b !== exp_b)   begin errors++; $display("FAIL cfg_dec_b got=%h exp=%h", dec_b, exp_b); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready got=%b exp=1", in_ready); end
    if (cfg_ack !== 1'b0)  begin errors++; $display("FAIL run_cfg_ack got=%b exp=0", cfg_ack); end
  endtask

  task automatic test_back_to_back;
    int i = 0, g = 0, e0 = 0;
    bit seen = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_z = {16'd0, 16'd0};
    while ((i < 8 || sb.size() != 0) && g < 80) begin
      if (in_valid) begin
        checks++;
        if (in_ready !== (sb.size() < FD)) begin
          errors++; $display("FAIL b2b_in_ready got=%b exp=%b", in_ready, sb.size() < FD);
        end
        if (in_ready) begin if (i == 0) e0 = cyc + 1; i++; end
      end
      if (!seen && out_valid) begin
        seen = 1; checks++;
        if (cyc != e0 + 4) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=4", cyc - e0); end
      end
      tick; g++;
      if (i < 8) in_z = {16'(i), 16'(i)}; else in_valid = 1'b0;
    end
    checks++;
    if (g >= 80 || !seen) begin errors++; $display("FAIL b2b_timeout cycles=%0d seen=%0d", g, seen); end
  endtask

  task automatic test_backpressure;
    int acc = 0, v = 100;
    out_ready = 1'b0; in_valid = 1'b1; in_z = {16'(v), 16'(v)};
    for (int c = 0; c < 10; c++) begin
      if (in_ready) begin acc++; v++; end
      tick; in_z = {16'(v), 16'(v)};
    end
    checks += 3;
    if (acc != 4)           begin errors++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
    out_ready = 1'b1; tick; out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (in_ready) begin acc++; v++; end
      tick; in_z = {16'(v), 16'(v)};
    end
    checks++;
    if (acc != 1) begin errors++; $display("FAIL bp_after_pop got=%0d exp=1", acc); end
    drain("bp");
  endtask

  task automatic test_drain;
    int e2, g = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_z = {16'd7, 16'd7};
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_pre_ready got=%b exp=1", in_ready); end
    tick; in_z = {16'd8, 16'd8};
    tick; in_valid = 1'b0; cfg_req = 1'b1;
    tick; cfg_req = 1'b0;
    e2 = cyc;
    checks += 2;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready got=%b exp=0", in_ready); end
    if (cfg_ack !== 1'b0)  begin errors++; $display("FAIL drain_cfg_ack got=%b exp=0", cfg_ack); end
    while (!cfg_ack && g < 20) begin tick; g++; end
    checks += 2;
    if (cyc != e2 + 4) begin errors++; $display("FAIL drain_ack_time got=%0d exp=4", cyc - e2); end
    if (sb.size() != 0) begin errors++; $display("FAIL drain_results left=%0d exp=0", sb.size()); end
  endtask

  task automatic test_cfg_err;
    cfg_wr = 1'b1; cfg_addr = 5'd27; cfg_wdata = 16'hDEAD; tick; cfg_wr = 1'b0;
    checks += 2;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", cfg_err); end
    if (dec_w !== exp_w || dec_b !== exp_b) begin errors++; $display("FAIL err_bank got=%h exp=%h", dec_b, exp_b); end
    cfg_done = 1'b1; tick; cfg_done = 1'b0;
    cfg_wr = 1'b1; cfg_addr = 5'd0; cfg_wdata = 16'hBEEF; tick; cfg_wr = 1'b0;
    checks += 2;
    if (dec_w !== exp_w)  begin errors++; $display("FAIL run_write got=%h exp=%h", dec_w, exp_w); end
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", cfg_err); end
    cfg_req = 1'b1; tick; cfg_req = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_drain got=%b exp=1", cfg_err); end
    tick;
    checks += 2;
    if (cfg_ack !== 1'b1) begin errors++; $display("FAIL err_reload_ack got=%b exp=1", cfg_ack); end
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", cfg_err); end
    cfg_done = 1'b1; tick; cfg_done = 1'b0;
  endtask

  task automatic test_reset_mid;
    int acc = 0, g = 0, e0 = 0, v = 200;
    out_ready = 1'b0; in_valid = 1'b1; in_z = {16'(v), 16'(v)};
    while (acc < 4 && g < 20) begin
      if (in_ready) begin if (acc == 0) e0 = cyc + 1; acc++; v++; end
      tick; g++; in_z = {16'(v), 16'(v)};
    end
    in_valid = 1'b0;
    while (cyc < e0 + 5 && g < 40) begin tick; g++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    reset = 1'b1; #1;
    checks += 8;
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    if (out_data !== '0)    begin errors++; $display("FAIL mid_out_data got=%h exp=0", out_data); end
    if (cfg_ack !== 1'b1)   begin errors++; $display("FAIL mid_cfg_ack got=%b exp=1", cfg_ack); end
    if (cfg_err !== 1'b0)   begin errors++; $display("FAIL mid_cfg_err got=%b exp=0", cfg_err); end
    if (dec_z !== '0)       begin errors++; $display("FAIL mid_dec_z got=%h exp=0", dec_z); end
    if (dec_w !== '0)       begin errors++; $display("FAIL mid_dec_w got=%h exp=0", dec_w); end
    if (dec_b !== '0)       begin errors++; $display("FAIL mid_dec_b got=%h exp=0", dec_b); end
    tick; tick; reset = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick; checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_valid cycle=%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset;
    test_config;
    test_back_to_back;
    test_backpressure;
    test_drain;
    test_cfg_err;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
